// File: rtl/alu_seq_pkg.sv
// Shared constants and FSM state type for the ALU sequencer.
// ST_MUL_INIT exists only when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

  localparam int unsigned ALU_NOP    = 0;
  localparam int unsigned ALU_ADD    = 1;
  localparam int unsigned ALU_SUB    = 2;
  localparam int unsigned ALU_OP_MAX = 8;
  localparam int unsigned SEQ_OP_MUL = 15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EXEC     = 3'd1,
    ST_WAIT     = 3'd2,
`ifdef ALU_SEQ_MUL_EN
    ST_MUL_INIT = 3'd4,
`endif
    ST_RESP     = 3'd3
  } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Request/response front-end for the registered 16-bit ALU.
// Optional feature macro ALU_SEQ_MUL_EN: op 15 becomes a multiply built from repeated ADDs.
//
// Handshakes: a transfer happens on the rising Clock edge where valid && ready are
// both high; the sender holds its payload stable while valid is high and ready is low.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [OP_W-1:0]   ALUOp,
  output logic [DATA_W-1:0] In_1,
  output logic [DATA_W-1:0] In_2,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic              Z,
  input  logic              Y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_z,
  output logic              rsp_y,
  output logic              rsp_err,
  output logic              busy
);

  seq_state_e        state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_z_q, rsp_z_d;
  logic              rsp_y_q, rsp_y_d;
  logic              rsp_err_q, rsp_err_d;
`ifdef ALU_SEQ_MUL_EN
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              sticky_q, sticky_d;
`endif

  function automatic logic op_is_alu(input logic [OP_W-1:0] op);
    return (op != '0) && (op <= OP_W'(ALU_OP_MAX));
  endfunction

`ifdef ALU_SEQ_MUL_EN
  function automatic logic op_is_mul(input logic [OP_W-1:0] op);
    return op == OP_W'(SEQ_OP_MUL);
  endfunction
`endif

  assign req_ready = (state_q == ST_IDLE) && Reset_n;
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_data  = rsp_data_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    rsp_z_d    = rsp_z_q;
    rsp_y_d    = rsp_y_q;
    rsp_err_d  = rsp_err_q;
    ALUOp      = OP_W'(ALU_NOP);
    In_1       = '0;
    In_2       = '0;
`ifdef ALU_SEQ_MUL_EN
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          a_d  = req_a;
          b_d  = req_b;
          // Illegal ops spend one cycle in WAIT (bus idle) so the error reply
          // has the same one-cycle latency as a zero-length multiply.
          if (op_is_alu(req_op)) state_d = ST_EXEC;
`ifdef ALU_SEQ_MUL_EN
          else if (op_is_mul(req_op)) state_d = ST_MUL_INIT;
`endif
          else state_d = ST_WAIT;
        end
      end
      ST_EXEC: begin
        ALUOp   = op_q;
        In_1    = a_q;
        In_2    = b_q;
`ifdef ALU_SEQ_MUL_EN
        if (op_is_mul(op_q)) begin
          ALUOp = OP_W'(ALU_ADD);
          In_1  = acc_q;
          In_2  = a_q;
        end
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_d = ST_RESP;
        if (op_is_alu(op_q)) begin
          rsp_data_d = ALUOut;
          rsp_z_d    = Z;
          rsp_y_d    = Y;
          rsp_err_d  = 1'b0;
        end
`ifdef ALU_SEQ_MUL_EN
        else if (op_is_mul(op_q)) begin
          acc_d    = ALUOut;
          cnt_d    = cnt_q - DATA_W'(1);
          sticky_d = sticky_q | Y;
          if (cnt_q == DATA_W'(1)) begin
            rsp_data_d = ALUOut;
            rsp_z_d    = (ALUOut == '0);
            rsp_y_d    = sticky_q | Y;
            rsp_err_d  = 1'b0;
          end else begin
            state_d = ST_EXEC;
          end
        end
`endif
        else begin
          rsp_data_d = '0;
          rsp_z_d    = 1'b1;
          rsp_y_d    = 1'b0;
          rsp_err_d  = 1'b1;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL_INIT: begin
        acc_d    = '0;
        cnt_d    = b_q;
        sticky_d = 1'b0;
        if (b_q == '0) begin
          rsp_data_d = '0;
          rsp_z_d    = 1'b1;
          rsp_y_d    = 1'b0;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else begin
          state_d = ST_EXEC;
        end
      end
`endif
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_z_q    <= 1'b0;
      rsp_y_q    <= 1'b0;
      rsp_err_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q      <= '0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      rsp_z_q    <= rsp_z_d;
      rsp_y_q    <= rsp_y_d;
      rsp_err_q  <= rsp_err_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, randomized requests, expected-queue scoreboard.
// Adapts its reference model to ALU_SEQ_MUL_EN.
module tb_alu_sequencer;

`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [3:0]  ALUOp;
  logic [15:0] In_1, In_2;
  logic [15:0] ALUOut = '0;
  logic        Z = 1'b0;
  logic        Y = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_z, rsp_y, rsp_err, busy;

  alu_sequencer #(.DATA_W(16), .OP_W(4)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .ALUOp(ALUOp), .In_1(In_1), .In_2(In_2),
    .ALUOut(ALUOut), .Z(Z), .Y(Y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_z(rsp_z), .rsp_y(rsp_y), .rsp_err(rsp_err),
    .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;

  logic [31:0] cyc = '0;
  always @(posedge Clock) cyc <= cyc + 1;

  // ---------------- behavioural ALU (one-cycle registered) ----------------
  function automatic logic [16:0] alu_fn(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
    case (op)
      4'd1:    return {1'b0, x} + {1'b0, y};
      4'd2:    return {(x < y), x - y};
      4'd3:    return {1'b0, x & y};
      4'd4:    return {1'b0, x | y};
      4'd5:    return {1'b0, x ^ y};
      4'd6:    return {1'b0, ~x};
      4'd7:    return {x[15], x << 1};
      4'd8:    return {x[0], x >> 1};
      default: return 17'd0;
    endcase
  endfunction

  always @(posedge Clock) begin
    logic [16:0] r;
    r = alu_fn(ALUOp, In_1, In_2);
    ALUOut <= r[15:0];
    Z      <= (r[15:0] == 16'd0);
    Y      <= r[16];
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [31:0] acc_cyc;
    logic [7:0]  lat;
    logic        err;
    logic        y;
    logic        z;
    logic [15:0] data;
  } exp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] in1;
    logic [15:0] in2;
  } iss_t;

  exp_t exp_q[$];
  iss_t iss_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   rdy_mode = 2;  // 0: hold low, 1: random, 2: always high

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: the response a request should produce, from the op rules directly.
  task automatic push_expect(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                             input logic [31:0] acc_cyc);
    exp_t        e;
    logic [16:0] r;
    logic [31:0] prod;
    iss_t        s;
    e.acc_cyc = acc_cyc;
    if (op >= 4'd1 && op <= 4'd8) begin
      r      = alu_fn(op, a, b);
      e.data = r[15:0];
      e.z    = (r[15:0] == 16'd0);
      e.y    = r[16];
      e.err  = 1'b0;
      e.lat  = 8'd2;
      s = '{op: op, in1: a, in2: b};
      iss_q.push_back(s);
    end else if (op == 4'd15 && MUL_EN) begin
      prod   = 32'(a) * 32'(b);
      e.data = prod[15:0];
      e.z    = (prod[15:0] == 16'd0);
      e.y    = (prod > 32'h0000_FFFF);
      e.err  = 1'b0;
      e.lat  = (b == 16'd0) ? 8'd1 : 8'(1 + 2 * int'(b));
      for (int k = 0; k < int'(b); k++) begin
        prod = 32'(k) * 32'(a);
        s = '{op: 4'd1, in1: prod[15:0], in2: a};
        iss_q.push_back(s);
      end
    end else begin
      e.data = 16'd0;
      e.z    = 1'b1;
      e.y    = 1'b0;
      e.err  = 1'b1;
      e.lat  = 8'd1;
    end
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks (called at posedge + #1) ----------------
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bit accepted = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    for (int t = 0; t < 300; t++) begin
      @(negedge Clock);
      if (req_ready) begin
        push_expect(op, a, b, cyc + 1);
        accepted = 1'b1;
        break;
      end
    end
    @(posedge Clock);
    #1;
    req_valid = 1'b0;
    req_op    = 4'($urandom);
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
    chk("req_accept", 64'(accepted), 64'd1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge Clock);
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 64'(done), 64'd1);
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_aluop"},     64'(ALUOp),     64'd0);
    chk({tag, "_in"},        64'({In_1, In_2}), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp"},       64'({rsp_data, rsp_z, rsp_y, rsp_err}), 64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
  endtask

  always begin
    @(posedge Clock);
    #1;
    case (rdy_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = ($urandom_range(0, 2) != 0);
      default: rsp_ready = 1'b1;
    endcase
  end

  // ---------------- monitor ----------------
  bit          in_resp = 1'b0;
  logic [18:0] held = '0;

  always @(negedge Clock) begin
    if (!Reset_n) begin
      in_resp = 1'b0;
    end else begin
      if (ALUOp != 4'd0) begin
        if (iss_q.size() == 0) chk("alu_issue_unexpected", 64'({ALUOp, In_1, In_2}), 64'd0);
        else chk("alu_issue", 64'({ALUOp, In_1, In_2}), 64'(iss_q.pop_front()));
      end else begin
        chk("idle_bus", 64'({In_1, In_2}), 64'd0);
      end
      if (rsp_valid) begin
        chk("req_ready_in_resp", 64'(req_ready), 64'd0);
        if (!in_resp) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 64'({rsp_data, rsp_z, rsp_y, rsp_err}), 64'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_payload", 64'({rsp_data, rsp_z, rsp_y, rsp_err}), 64'({e.data, e.z, e.y, e.err}));
            chk("rsp_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
          end
          in_resp = 1'b1;
          held    = {rsp_data, rsp_z, rsp_y, rsp_err};
        end else begin
          chk("rsp_stable", 64'({rsp_data, rsp_z, rsp_y, rsp_err}), 64'(held));
        end
        if (rsp_ready) in_resp = 1'b0;
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    bit   seen;
    int   issues;
    logic [3:0]  op;
    logic [15:0] a, b;

    repeat (3) @(posedge Clock);
    #1;
    chk_reset_outputs("reset");
    @(negedge Clock);
    Reset_n = 1'b1;
    #1;
    chk("ready_after_reset", 64'(req_ready), 64'd1);
    @(posedge Clock);
    #1;

    send(4'd1, 16'd5, 16'd3);
    wait_idle();

    // SUB to zero, consumer stalls four cycles
    rdy_mode = 0;
    send(4'd2, 16'd3, 16'd3);
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge Clock);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge Clock);
    chk("rsp_held_valid", 64'({seen, rsp_valid}), 64'b11);
    rdy_mode = 1;
    wait_idle();

    send(4'd0, 16'd7, 16'd9);
    send(4'd12, 16'd1, 16'd2);
    send(4'd15, 16'd7, 16'd3);
    send(4'd15, 16'd5, 16'd3);
    send(4'd15, 16'h8000, 16'd2);
    send(4'd15, 16'd9, 16'd0);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = (op == 4'd15) ? 16'($urandom_range(0, 6)) : 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = b;
      send(op, a, b);
    end
    wait_idle();

    // Reset while the third ALU issue of a long multiply (or the single ADD) is on the bus
    send(MUL_EN ? 4'd15 : 4'd1, 16'd5, 16'd10);
    issues = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge Clock);
      if (ALUOp != 4'd0) issues++;
      if (issues == (MUL_EN ? 3 : 1)) break;
    end
    Reset_n = 1'b0;
    #1;
    chk("reset_hit_exec", 64'(issues), MUL_EN ? 64'd3 : 64'd1);
    chk_reset_outputs("midreset");
    exp_q.delete();
    iss_q.delete();
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge Clock);
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_reset", 64'(seen), 64'd0);
    @(posedge Clock);
    #1;
    send(4'd1, 16'd5, 16'd3);
    wait_idle();

    chk("exp_q_drained", 64'(exp_q.size() + iss_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
